// File: rtl/fft_mem_pkg.sv
// Shared types and helpers for the FFT sample-buffer controller.
package fft_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_HOLD  = 2'd2
  } fft_mem_state_e;

  // Reverses the low 'width' bits of x; bits above 'width' come back as zero.
  // Built by shifting so no variable bit-select is needed.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int width);
    logic [31:0] r;
    logic [31:0] x_sh;
    r    = '0;
    x_sh = x;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r    = {r[30:0], x_sh[0]};
        x_sh = x_sh >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_loader.sv
// Loads one FFT frame into the sample memory at bit-reversed addresses, then
// streams it back out in natural address order.
//
// state       | meaning
// ------------|-----------------------------------------------------------
// ST_LOAD     | accepting input samples, writing memory at bitrev(wr_cnt)
// ST_RD_ISSUE | first read of the frame issued at address 0
// ST_RD_HOLD  | read data presented on m_*, next read issued on handshake
module fft_bitrev_loader
  import fft_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADRR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADRR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  frame_done
);

  localparam logic [ADRR_WIDTH-1:0] CNT_LAST = '1;
  localparam logic [ADRR_WIDTH-1:0] CNT_ONE  = ADRR_WIDTH'(1);

  fft_mem_state_e        state_q, state_d;
  logic [ADRR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADRR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                  frame_done_q, frame_done_d;

  assign frame_done = frame_done_q;

  // Next-state and memory/stream output decode; everything forced quiet in reset.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    frame_done_d = 1'b0;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    m_data       = '0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          mem_we    = 1'b1;
          mem_addr  = ADRR_WIDTH'(bitrev(32'(wr_cnt_q), ADRR_WIDTH));
          mem_wdata = s_data;
          if (wr_cnt_q == CNT_LAST) begin
            wr_cnt_d = '0;
            state_d  = ST_RD_ISSUE;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
          end
        end
      end

      ST_RD_ISSUE: begin
        mem_re   = 1'b1;
        mem_addr = rd_cnt_q;
        state_d  = ST_RD_HOLD;
      end

      ST_RD_HOLD: begin
        m_valid = 1'b1;
        m_data  = mem_rdata;
        // Without m_ready the memory holds rdata because re and we stay low.
        if (m_ready) begin
          if (rd_cnt_q != CNT_LAST) begin
            mem_re   = 1'b1;
            mem_addr = rd_cnt_q + CNT_ONE;
            rd_cnt_d = rd_cnt_q + CNT_ONE;
          end else begin
            rd_cnt_d     = '0;
            frame_done_d = 1'b1;
            state_d      = ST_LOAD;
          end
        end
      end

      default: begin
        state_d  = ST_LOAD;
        wr_cnt_d = '0;
        rd_cnt_d = '0;
      end
    endcase

    if (rst) begin
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      m_data    = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // State, counters and the registered frame_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
